sa_fifo_rwsp_160x514: RTL and testbench
=======================================

SA_FIFO_RWSP_160X514 -- requirements
Module: sa_fifo_rwsp_160x514

Interface
REQ-001 Parameters SHALL be, one per line:
- DEPTH, 160, entries.
- AW, 8, pointer width.
- DW, 514, payload width.
- Only the defaults SHALL be legal.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 wr_pvld  input  1  write payload valid.
REQ-005 wr_prdy  output  1  FIFO can accept a write.
REQ-006 wr_pd  input  514  write payload.
REQ-007 rd_pvld  output  1  read payload valid.
REQ-008 rd_prdy  input  1  consumer accepts the read payload.
REQ-009 rd_pd  output  514  read payload.
REQ-010 fifo_count  output  8  occupied entries, 0..160.
REQ-011 fifo_idle  output  1  high when fifo_count==0 and no read is in flight.
REQ-012 pwrbus_ram_pd  input  32  passed unchanged to the RAM.

Function
REQ-013 Push SHALL occur when wr_pvld & wr_prdy; pop SHALL occur when rd_pvld & rd_prdy.
REQ-014 wr_prdy SHALL equal (count != 160) from the count register; a pop in the same cycle SHALL NOT enable a push while full.
REQ-015 Push SHALL drive RAM we=1, wa=wptr, di=wr_pd in the same cycle, then advance wptr.
REQ-016 wptr and rptr SHALL wrap 159 -> 0; values 160..255 SHALL never occur.
REQ-017 count SHALL be +1 on push-only, -1 on pop-only, and unchanged on push+pop or neither.
REQ-018 Internal counter unissued SHALL track entries written but not yet read from the RAM.
REQ-019 A push SHALL make its entry readable from the next cycle at the earliest.
REQ-020 The read pipeline SHALL have two stages: s1 (address latched in the RAM) and s2 (RAM output register holds data).
REQ-021 ore SHALL be s1_vld & (!s2_vld | pop); on ore, s2_vld<=1 and s1_vld clears unless a new read issues.
REQ-022 re SHALL be (unissued!=0) & (!s1_vld | ore); ra=rptr; on re, rptr advances and s1_vld<=1.
REQ-023 s2_vld SHALL clear on pop when no ore occurs.
REQ-024 rd_pvld SHALL equal s2_vld and rd_pd SHALL equal the RAM dout.
REQ-025 rd_pd SHALL hold stable while rd_pvld & !rd_prdy.
REQ-026 The RAM slot SHALL be freed only on pop, so no write can target an address still in s1/s2.
REQ-027 Latency on an empty FIFO SHALL be 3 cycles: push at cycle t, re at t+1, ore at t+2, rd_pvld at t+3.
REQ-028 With rd_prdy held high and continuous pushes, throughput SHALL be 1 entry/cycle.
REQ-029 Entries SHALL be delivered in strict FIFO order with no loss or duplication.

Reset
REQ-030 While reset: wptr, rptr, count, unissued, s1_vld and s2_vld SHALL be 0.
REQ-031 While reset: we, re and ore SHALL be 0.
REQ-032 While reset: rd_pvld=0, fifo_count=0, fifo_idle=1.
REQ-033 wr_prdy SHALL be 1 from the first cycle after reset deasserts.
REQ-034 Reset mid-operation SHALL discard all stored and in-flight data; RAM contents SHALL NOT be cleared.
REQ-035 rd_pd SHALL be don't-care while rd_pvld=0.

Structure
REQ-036 DEPTH, AW, DW and the pointer-wrap constant SHALL live in the shared sa_ram package.
REQ-037 The block SHALL instantiate exactly one sub-module, sa_ram_rwsp_160x514.
REQ-038 FORCE_CONTENTION_ASSERTION_RESET_ACTIVE SHALL stay at the RAM default.
REQ-039 All control logic SHALL be in this module.

Verification
REQ-040 Single push 0x155 into an empty FIFO, rd_prdy=1 -> rd_pvld rises exactly 3 cycles later with rd_pd=0x155; fifo_count goes 0,1,1,1,0.
REQ-041 160 pushes with rd_prdy=0 -> wr_prdy=0 and fifo_count=160; a 161st wr_pvld is not accepted; one pop -> wr_prdy=1 the next cycle.
REQ-042 Streaming 500 incrementing payloads with rd_prdy=1 -> in-order output at 1/cycle after the 3-cycle fill; wptr/rptr wrap at least 3 times.
REQ-043 Random rd_prdy (50%) over 1000 payloads -> rd_pd stable during every stall; no loss, duplication or reorder.
REQ-044 Push and pop in the same cycle at count=1 and at count=160 -> count unchanged at 1; at 160 the push is refused.
REQ-045 Reset asserted with count=40 and s1/s2 valid -> next cycle rd_pvld=0, fifo_count=0, fifo_idle=1; the first new push reads back correctly.

Source files
------------

// File: rtl/sa_ram_pkg.sv
// Shared geometry for the 160x514 single-port-read/write FIFO RAM and its controller.
// Pointers run 0..SA_PTR_LAST and wrap back to zero.
package sa_ram_pkg;

  localparam int SA_DEPTH = 160;
  localparam int SA_AW    = 8;
  localparam int SA_DW    = 514;

  localparam logic [SA_AW-1:0] SA_PTR_LAST = 8'd159;

  // Advance a RAM pointer, skipping the unused 160..255 range.
  function automatic logic [SA_AW-1:0] ptr_inc(input logic [SA_AW-1:0] ptr);
    return (ptr == SA_PTR_LAST) ? '0 : ptr + 8'd1;
  endfunction

endpackage

// File: rtl/sa_ram_rwsp_160x514.sv
// 160x514 RAM: one write port, one read port with a latched address (re) and a
// separate output register enable (ore), giving a two-stage read.
module sa_ram_rwsp_160x514
  import sa_ram_pkg::*;
#(
  parameter bit FORCE_CONTENTION_ASSERTION_RESET_ACTIVE = 1'b0
) (
  input  logic              clk,
  input  logic [31:0]       pwrbus_ram_pd,
  input  logic [SA_AW-1:0]  ra,
  input  logic              re,
  input  logic              ore,
  output logic [SA_DW-1:0]  dout,
  input  logic [SA_AW-1:0]  wa,
  input  logic              we,
  input  logic [SA_DW-1:0]  di
);

  logic [SA_DW-1:0] mem [0:SA_DEPTH-1];
  logic [SA_AW-1:0] ra_reg;

  // Power-bus and contention controls have no effect on this behavioural array.
  logic unused_ctrl;
  assign unused_ctrl = (^pwrbus_ram_pd) ^ FORCE_CONTENTION_ASSERTION_RESET_ACTIVE;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= di;
    end
    if (re) begin
      ra_reg <= ra;
    end
    if (ore) begin
      dout <= mem[ra_reg];
    end
  end

endmodule

// File: rtl/sa_fifo_rwsp_160x514.sv
// 160-entry x 514-bit valid/ready FIFO over a two-stage-read RAM; entries stay
// allocated until popped, so writes never hit an address still being read.
module sa_fifo_rwsp_160x514
  import sa_ram_pkg::*;
#(
  parameter int DEPTH = SA_DEPTH,
  parameter int AW    = SA_AW,
  parameter int DW    = SA_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic [AW-1:0] fifo_count,
  output logic          fifo_idle,
  input  logic [31:0]   pwrbus_ram_pd
);

  logic [AW-1:0] wptr_reg, wptr_next;
  logic [AW-1:0] rptr_reg, rptr_next;
  logic [AW-1:0] count_reg, count_next;
  logic [AW-1:0] unissued_reg, unissued_next;
  logic          s1_vld_reg, s1_vld_next;
  logic          s2_vld_reg, s2_vld_next;

  logic push, pop, we, re, ore;

  // Fullness comes from the registered count only, so a same-cycle pop never frees a slot.
  assign wr_prdy = (count_reg != AW'(DEPTH));
  assign push    = wr_pvld & wr_prdy & ~reset;
  assign pop     = s2_vld_reg & rd_prdy & ~reset;
  assign we      = push;

  assign ore = s1_vld_reg & (~s2_vld_reg | pop) & ~reset;
  assign re  = (unissued_reg != '0) & (~s1_vld_reg | ore) & ~reset;

  always_comb begin
    wptr_next     = push ? ptr_inc(wptr_reg) : wptr_reg;
    rptr_next     = re   ? ptr_inc(rptr_reg) : rptr_reg;
    count_next    = count_reg;
    unissued_next = unissued_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + AW'(1);
      2'b01:   count_next = count_reg - AW'(1);
      default: count_next = count_reg;
    endcase
    case ({push, re})
      2'b10:   unissued_next = unissued_reg + AW'(1);
      2'b01:   unissued_next = unissued_reg - AW'(1);
      default: unissued_next = unissued_reg;
    endcase
    s1_vld_next = re  ? 1'b1 : (ore ? 1'b0 : s1_vld_reg);
    s2_vld_next = ore ? 1'b1 : (pop ? 1'b0 : s2_vld_reg);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      count_reg    <= '0;
      unissued_reg <= '0;
      s1_vld_reg   <= 1'b0;
      s2_vld_reg   <= 1'b0;
    end else begin
      wptr_reg     <= wptr_next;
      rptr_reg     <= rptr_next;
      count_reg    <= count_next;
      unissued_reg <= unissued_next;
      s1_vld_reg   <= s1_vld_next;
      s2_vld_reg   <= s2_vld_next;
    end
  end

  assign rd_pvld    = s2_vld_reg;
  assign fifo_count = count_reg;
  assign fifo_idle  = (count_reg == '0) & ~s1_vld_reg & ~s2_vld_reg;

  sa_ram_rwsp_160x514 u_ram (
    .clk           (clk),
    .pwrbus_ram_pd (pwrbus_ram_pd),
    .ra            (rptr_reg),
    .re            (re),
    .ore           (ore),
    .dout          (rd_pd),
    .wa            (wptr_reg),
    .we            (we),
    .di            (wr_pd)
  );

endmodule

// File: tb/tb_sa_fifo_rwsp_160x514.sv
// Directed bench for sa_fifo_rwsp_160x514: latency, full/refuse, streaming,
// random back-pressure and mid-operation reset, checked against a queue model.
module tb_sa_fifo_rwsp_160x514;
  import sa_ram_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_pvld;
  logic              wr_prdy;
  logic [SA_DW-1:0]  wr_pd;
  logic              rd_pvld;
  logic              rd_prdy;
  logic [SA_DW-1:0]  rd_pd;
  logic [SA_AW-1:0]  fifo_count;
  logic              fifo_idle;
  logic [31:0]       pwrbus_ram_pd;

  int errors = 0;
  int checks = 0;
  int model_cnt = 0;
  int pops = 0;
  logic [SA_DW-1:0] exp_q [$];
  bit               stall_reg = 1'b0;
  logic [SA_DW-1:0] stall_pd;

  always #5 clk = ~clk;

  sa_fifo_rwsp_160x514 dut (
    .clk           (clk),
    .reset         (reset),
    .wr_pvld       (wr_pvld),
    .wr_prdy       (wr_prdy),
    .wr_pd         (wr_pd),
    .rd_pvld       (rd_pvld),
    .rd_prdy       (rd_prdy),
    .rd_pd         (rd_pd),
    .fifo_count    (fifo_count),
    .fifo_idle     (fifo_idle),
    .pwrbus_ram_pd (pwrbus_ram_pd)
  );

  task automatic check(input string tag, input logic [SA_DW-1:0] obs, input logic [SA_DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SA_DW-1:0] mk(input int k);
    logic [31:0] w;
    w = 32'(k * 7 + 1);
    return {k[1:0], {16{w}}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock of traffic: checks current outputs against the model, then advances.
  task automatic cycle(input bit push_en, input logic [SA_DW-1:0] pd, input bit pop_en);
    bit acc, popd;
    logic [SA_DW-1:0] e;
    wr_pvld = push_en;
    wr_pd   = pd;
    rd_prdy = pop_en;
    check("wr_prdy", wr_prdy, model_cnt != SA_DEPTH);
    if (stall_reg) begin
      check("stall_vld", rd_pvld, 1);
      check("stall_pd", rd_pd, stall_pd);
    end
    acc  = push_en && (model_cnt != SA_DEPTH);
    popd = rd_pvld && pop_en;
    if (popd) begin
      pops++;
      check("q_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rd_pd", rd_pd, e);
      end
    end
    stall_reg = rd_pvld && !pop_en;
    stall_pd  = rd_pd;
    if (acc) exp_q.push_back(pd);
    model_cnt = model_cnt + int'(acc) - int'(popd);
    step();
    check("count", fifo_count, model_cnt);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (exp_q.size() != 0 || fifo_count != 0); i++) begin
      cycle(1'b0, '0, 1'b1);
    end
    check("drain_done", exp_q.size() + int'(fifo_count), 0);
    check("idle_after_drain", fifo_idle, 1);
  endtask

  initial begin
    int sent;
    int p0;
    reset = 1'b1; wr_pvld = 1'b0; wr_pd = '0; rd_prdy = 1'b0;
    pwrbus_ram_pd = 32'h0;
    step(); step(); step();
    check("rst_pvld", rd_pvld, 0);
    check("rst_count", fifo_count, 0);
    check("rst_idle", fifo_idle, 1);
    reset = 1'b0;
    step();
    check("post_rst_prdy", wr_prdy, 1);

    // Single push: rd_pvld exactly 3 cycles later, count 0,1,1,1,0.
    wr_pvld = 1'b1; wr_pd = SA_DW'(16'h155); rd_prdy = 1'b1;
    check("lat_cnt_t0", fifo_count, 0);
    check("lat_vld_t0", rd_pvld, 0);
    step();
    wr_pvld = 1'b0;
    check("lat_cnt_t1", fifo_count, 1);
    check("lat_vld_t1", rd_pvld, 0);
    step();
    check("lat_cnt_t2", fifo_count, 1);
    check("lat_vld_t2", rd_pvld, 0);
    step();
    check("lat_cnt_t3", fifo_count, 1);
    check("lat_vld_t3", rd_pvld, 1);
    check("lat_pd_t3", rd_pd, SA_DW'(16'h155));
    step();
    check("lat_cnt_t4", fifo_count, 0);
    check("lat_vld_t4", rd_pvld, 0);
    check("lat_idle_t4", fifo_idle, 1);

    // Fill to 160, refuse the 161st, then push+pop at full.
    for (int i = 0; i < SA_DEPTH; i++) cycle(1'b1, mk(i), 1'b0);
    check("full_prdy", wr_prdy, 0);
    check("full_count", fifo_count, SA_DEPTH);
    cycle(1'b1, mk(999), 1'b0);
    check("full_refuse_cnt", fifo_count, SA_DEPTH);
    cycle(1'b1, mk(998), 1'b1);
    check("full_pushpop_cnt", fifo_count, SA_DEPTH - 1);
    check("prdy_after_pop", wr_prdy, 1);
    drain();

    // Push+pop at count=1 keeps count at 1.
    cycle(1'b1, mk(500), 1'b0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    check("c1_vld", rd_pvld, 1);
    cycle(1'b1, mk(501), 1'b1);
    check("c1_pushpop_cnt", fifo_count, 1);
    drain();

    // Streaming 500 payloads at one per cycle.
    p0 = pops;
    for (int k = 0; k < 500; k++) cycle(1'b1, mk(1000 + k), 1'b1);
    check("stream_pops", pops - p0, 497);
    drain();

    // Random back-pressure over 1000 payloads.
    sent = 0;
    for (int c = 0; c < 6000 && sent < 1000; c++) begin
      if (model_cnt != SA_DEPTH) begin
        cycle(1'b1, mk(3000 + sent), 1'($urandom_range(0, 1)));
        sent++;
      end else begin
        cycle(1'b1, mk(3000 + sent), 1'($urandom_range(0, 1)));
      end
    end
    check("rand_sent", sent, 1000);
    drain();

    // Reset with 40 entries and both read stages valid.
    for (int i = 0; i < 40; i++) cycle(1'b1, mk(7000 + i), 1'b0);
    cycle(1'b0, '0, 1'b0);
    check("pre_rst_vld", rd_pvld, 1);
    check("pre_rst_cnt", fifo_count, 40);
    reset = 1'b1; wr_pvld = 1'b0; rd_prdy = 1'b0;
    step();
    check("midrst_vld", rd_pvld, 0);
    check("midrst_cnt", fifo_count, 0);
    check("midrst_idle", fifo_idle, 1);
    reset = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    stall_reg = 1'b0;
    step();
    cycle(1'b1, mk(77), 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
